// File: rtl/ma_fir_stream_sequencer.sv
// ma_fir_stream_sequencer
// Streaming front-end for a moving-average FIR that has no enable and consumes
// one sample per clock. Bursty valid/ready input is buffered in a FIFO, primed
// to START_LEVEL entries, then popped back-to-back onto the filter input.
// Starvation drops back to FILL with a sticky underrun flag; flush (and reset
// release) holds the filter in reset for FLUSH_CYCLES clocks. Filter results
// are registered and tagged valid only once TAPS consecutive real samples
// are behind them.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   s_data/s_valid/s_ready  input sample stream (transfer on valid && ready)
//   flush                   one-cycle request: drop buffer, reset filter
//   underrun_clr            clears the sticky underrun flag
//   fir_d, fir_reset_n      registered sample and reset driven to the filter
//   fir_q_8tap, fir_q_rma   filter results
//   m_q_8tap, m_q_rma       registered filter results
//   m_valid                 m_q_* backed by a full window of real samples
//   state_o                 00 FLUSH, 01 FILL, 10 RUN
//   underrun                sticky starvation flag
module ma_fir_stream_sequencer #(
  parameter int DATA_W           = 16,
  parameter int FIFO_DEPTH       = 16,
  parameter int START_LEVEL      = 4,
  parameter int TAPS             = 8,
  parameter int FIR_LATENCY      = 1,
  parameter int FLUSH_CYCLES     = 2,
  parameter int HOLD_ON_UNDERRUN = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     flush,
  input  logic                     underrun_clr,
  output logic signed [DATA_W-1:0] fir_d,
  output logic                     fir_reset_n,
  input  logic signed [DATA_W-1:0] fir_q_8tap,
  input  logic signed [DATA_W-1:0] fir_q_rma,
  output logic signed [DATA_W-1:0] m_q_8tap,
  output logic signed [DATA_W-1:0] m_q_rma,
  output logic                     m_valid,
  output logic [1:0]               state_o,
  output logic                     underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TAPS + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  // Tag stages: one for the fir_d register, FIR_LATENCY inside the filter,
  // one for the m_q_* capture register.
  localparam int VP = FIR_LATENCY + 2;

  typedef enum logic [1:0] {
    S_FLUSH = 2'b00,
    S_FILL  = 2'b01,
    S_RUN   = 2'b10
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wptr, r_rptr;
  logic [CW-1:0]            r_count, w_occ_push;
  logic [FW-1:0]            r_flush_cnt, w_flush_cnt_nxt;
  logic [WW-1:0]            r_warm;
  logic signed [DATA_W-1:0] r_hold, r_fir_d, r_q8, r_qrma, w_head;
  logic                     r_fir_reset_n, r_underrun;
  logic [VP-1:0]            r_vld_p;
  logic                     w_full, w_empty, w_push, w_pop, w_starve, w_tag;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rptr];
  assign s_ready    = (r_state != S_FLUSH) && !w_full;
  // A flush discards whatever is offered in the same cycle.
  assign w_push     = s_valid && s_ready && !flush;
  assign w_occ_push = r_count + CW'(w_push);
  // The TAPS-th consecutive pop is the first one with a full real window.
  assign w_tag      = w_pop && (r_warm >= WW'(TAPS - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_pop           = 1'b0;
    w_starve        = 1'b0;
    if (flush) begin
      w_state_nxt     = S_FLUSH;
      w_flush_cnt_nxt = FW'(FLUSH_CYCLES);
    end else begin
      case (r_state)
        S_FLUSH: begin
          if (r_flush_cnt <= FW'(1)) w_state_nxt = S_FILL;
          else                       w_flush_cnt_nxt = r_flush_cnt - 1'b1;
        end
        S_FILL: begin
          if (w_occ_push >= CW'(START_LEVEL)) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_empty) begin
            w_starve    = 1'b1;
            w_state_nxt = S_FILL;
          end else begin
            w_pop = 1'b1;
          end
        end
        default: w_state_nxt = S_FLUSH;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  // Control, pointers, filter drive, tag pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_FLUSH;
      r_flush_cnt   <= FW'(FLUSH_CYCLES);
      r_fir_reset_n <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_warm        <= '0;
      r_hold        <= '0;
      r_fir_d       <= '0;
      r_vld_p       <= '0;
      r_underrun    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_fir_reset_n <= (w_state_nxt != S_FLUSH);
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_warm  <= '0;
        r_hold  <= '0;
        r_fir_d <= '0;
        r_vld_p <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        r_count <= w_occ_push - CW'(w_pop);
        if (w_starve)                           r_warm <= '0;
        else if (w_pop && r_warm != WW'(TAPS))  r_warm <= r_warm + 1'b1;
        if (r_state == S_FLUSH)                     r_hold <= '0;
        else if (w_pop && HOLD_ON_UNDERRUN != 0)    r_hold <= w_head;
        if (w_pop)                   r_fir_d <= w_head;
        else if (r_state == S_FLUSH) r_fir_d <= '0;
        else                         r_fir_d <= r_hold;
        r_vld_p <= {r_vld_p[VP-2:0], w_tag};
      end
      // Set wins over clear.
      if (w_starve)          r_underrun <= 1'b1;
      else if (underrun_clr) r_underrun <= 1'b0;
    end
  end

  // Result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q8   <= '0;
      r_qrma <= '0;
    end else begin
      r_q8   <= fir_q_8tap;
      r_qrma <= fir_q_rma;
    end
  end

  assign fir_d       = r_fir_d;
  assign fir_reset_n = r_fir_reset_n;
  assign m_q_8tap    = r_q8;
  assign m_q_rma     = r_qrma;
  assign m_valid     = r_vld_p[VP-1];
  assign state_o     = r_state;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_ma_fir_stream_sequencer.sv
// Testbench for ma_fir_stream_sequencer: stub moving-average filter, a
// queue-based reference model, directed scenarios and randomized traffic.
module tb_ma_fir_stream_sequencer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int START = 4;
  localparam int TAPS  = 8;
  localparam int LAT   = 1;
  localparam int FLC   = 2;
  localparam int HOLD  = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [DW-1:0] s_data = '0;
  logic s_valid = 1'b0, flush = 1'b0, underrun_clr = 1'b0;

  logic                 s_ready, fir_reset_n, m_valid, underrun;
  logic signed [DW-1:0] fir_d, m_q_8tap, m_q_rma, fir_q_8tap, fir_q_rma;
  logic [1:0]           state_o;

  logic                 s_ready2, fir_reset_n2, m_valid2, underrun2;
  logic signed [DW-1:0] fir_d2, m_q_8tap2, m_q_rma2;
  logic [1:0]           state2;

  always #5 clk = ~clk;

  ma_fir_stream_sequencer #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .START_LEVEL(START), .TAPS(TAPS),
    .FIR_LATENCY(LAT), .FLUSH_CYCLES(FLC), .HOLD_ON_UNDERRUN(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .underrun_clr(underrun_clr),
    .fir_d(fir_d), .fir_reset_n(fir_reset_n), .fir_q_8tap(fir_q_8tap),
    .fir_q_rma(fir_q_rma), .m_q_8tap(m_q_8tap), .m_q_rma(m_q_rma),
    .m_valid(m_valid), .state_o(state_o), .underrun(underrun)
  );

  // Second instance primed to a full FIFO before running.
  ma_fir_stream_sequencer #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .START_LEVEL(16), .TAPS(TAPS),
    .FIR_LATENCY(LAT), .FLUSH_CYCLES(FLC), .HOLD_ON_UNDERRUN(HOLD)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready2), .flush(flush), .underrun_clr(underrun_clr),
    .fir_d(fir_d2), .fir_reset_n(fir_reset_n2), .fir_q_8tap('0),
    .fir_q_rma('0), .m_q_8tap(m_q_8tap2), .m_q_rma(m_q_rma2),
    .m_valid(m_valid2), .state_o(state2), .underrun(underrun2)
  );

  // Stub filter: 8-tap average with one clock of latency, plus a scrambled
  // copy of the input as the recursive output.
  logic signed [DW-1:0] h [8];
  int acc;
  always @(posedge clk) begin
    if (!fir_reset_n) begin
      for (int i = 0; i < 8; i++) h[i] <= '0;
      fir_q_rma <= '0;
    end else begin
      h[0] <= fir_d;
      for (int i = 1; i < 8; i++) h[i] <= h[i-1];
      fir_q_rma <= fir_d ^ 16'sh0F0F;
    end
  end
  always_comb begin
    acc = 0;
    for (int i = 0; i < 8; i++) acc += int'(h[i]);
    fir_q_8tap = DW'(acc >>> 3);
  end

  int n_chk = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Reference model
  int md, fcnt, warm;
  logic signed [DW-1:0] fq[$];
  bit tq[$];
  logic signed [DW-1:0] hold_e, fird_e, prev8, prevr;
  bit frst_e, und_e, prev_ok;

  task automatic model_reset();
    md = 0; fcnt = FLC; warm = 0; fq.delete(); tq.delete();
    hold_e = '0; fird_e = '0; frst_e = 0; und_e = 0; prev_ok = 0;
  endtask

  task automatic model_step();
    bit rdy, push, tag, starve;
    logic signed [DW-1:0] v;
    rdy = (md != 0) && (fq.size() < DEPTH);
    push = s_valid && rdy && !flush;
    tag = 0; starve = 0;
    if (flush) begin
      md = 0; fcnt = FLC; fq.delete(); warm = 0; hold_e = '0; fird_e = '0; frst_e = 0;
      tq.delete();
      for (int i = 0; i < LAT + 2; i++) tq.push_back(1'b0);
    end else begin
      case (md)
        0: begin
          fird_e = '0; hold_e = '0;
          if (fcnt <= 1) begin md = 1; frst_e = 1; end
          else fcnt--;
        end
        1: begin
          if (push) fq.push_back(s_data);
          fird_e = hold_e;
          if (fq.size() >= START) md = 2;
        end
        default: begin
          if (fq.size() == 0) begin
            starve = 1; fird_e = hold_e; warm = 0; md = 1;
          end else begin
            v = fq.pop_front();
            fird_e = v;
            if (HOLD != 0) hold_e = v;
            tag = (warm >= TAPS - 1);
            if (warm < TAPS) warm++;
          end
          if (push) fq.push_back(s_data);
        end
      endcase
      tq.push_back(tag);
      if (tq.size() > LAT + 2) void'(tq.pop_front());
    end
    if (starve) und_e = 1;
    else if (underrun_clr) und_e = 0;
  endtask

  function automatic bit exp_mvalid();
    return (tq.size() == LAT + 2) ? tq[0] : 1'b0;
  endfunction

  task automatic check_all();
    check_eq("state", 32'(state_o), md);
    check_eq("fir_d", fir_d, fird_e);
    check_eq("fir_reset_n", fir_reset_n, frst_e);
    check_eq("s_ready", s_ready, (md != 0) && (fq.size() < DEPTH));
    check_eq("m_valid", m_valid, exp_mvalid());
    check_eq("underrun", underrun, und_e);
    if (prev_ok) begin
      check_eq("m_q_8tap", m_q_8tap, prev8);
      check_eq("m_q_rma", m_q_rma, prevr);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    prev8 = fir_q_8tap; prevr = fir_q_rma; prev_ok = 1;
  endtask

  // Called at a negedge; reset lands between clock edges.
  task automatic do_reset();
    s_valid = 0; flush = 0; underrun_clr = 0;
    #2 reset_n = 0;
    #1 model_reset();
    check_all();
    check_eq("rst_mq8", m_q_8tap, 0);
    check_eq("rst_mqrma", m_q_rma, 0);
    check_eq("rst2_state", 32'(state2), 0);
    check_eq("rst2_frst", fir_reset_n2, 0);
    check_eq("rst2_ready", s_ready2, 0);
    check_eq("rst2_out", {m_valid2, underrun2, fir_d2, m_q_8tap2 | m_q_rma2}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  int mv_cnt, idx, seen_run;
  bit rdy2;
  logic signed [DW-1:0] smp [17];

  initial begin
    @(negedge clk);
    do_reset();

    // Warm-up after reset release
    cycle();
    check_eq("t1_frst_lo", fir_reset_n, 0);
    cycle();
    check_eq("t1_frst_hi", fir_reset_n, 1);
    check_eq("t1_fill", 32'(state_o), 1);
    check_eq("t1_ready", s_ready, 1);

    // Twelve full-scale samples, then starve with underrun_clr held
    mv_cnt = 0;
    s_valid = 1; s_data = 16'sh7FFF;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i == 3) check_eq("t2_run", 32'(state_o), 2);
      if (m_valid) begin mv_cnt++; check_eq("t2_mq", m_q_8tap, 16'h7FFF); end
    end
    s_valid = 0; underrun_clr = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) underrun_clr = 0;
      cycle();
      if (m_valid) begin mv_cnt++; check_eq("t2_mq", m_q_8tap, 16'h7FFF); end
    end
    check_eq("t2_mvcnt", mv_cnt, 5);
    check_eq("t2_fird", fir_d, 0);

    // Impulse followed by zeros
    s_valid = 1;
    for (int i = 0; i < 18; i++) begin
      s_data = (i == 0) ? 16'sh7FFF : 16'sh0000;
      cycle();
    end
    s_valid = 0;
    repeat (10) cycle();

    // Flush with entries queued; a push offered alongside is dropped
    s_valid = 1;
    for (int i = 0; i < 8; i++) begin s_data = DW'($urandom); cycle(); end
    flush = 1; s_data = 16'sh1234;
    cycle();
    flush = 0; s_valid = 0;
    check_eq("t5_state", 32'(state_o), 0);
    check_eq("t5_frst", fir_reset_n, 0);
    check_eq("t5_mvalid", m_valid, 0);
    repeat (3) cycle();
    s_valid = 1;
    for (int i = 0; i < 14; i++) begin s_data = DW'($urandom); cycle(); end
    s_valid = 0;
    repeat (10) cycle();

    // Full-depth priming on the second instance
    do_reset();
    repeat (3) cycle();
    for (int i = 0; i < 17; i++) smp[i] = DW'((i << 10) | $urandom_range(1, 1023));
    idx = 0; seen_run = 0;
    for (int c = 0; c < 60 && seen_run == 0; c++) begin
      s_valid = (idx < 17); s_data = smp[(idx < 17) ? idx : 16];
      rdy2 = s_ready2;
      cycle();
      if (rdy2 && idx < 17) idx++;
      if (state2 == 2'b10) seen_run = 1;
    end
    check_eq("t4_run", seen_run, 1);
    check_eq("t4_acc16", idx, 16);
    for (int k = 0; k < 18; k++) begin
      s_valid = (idx < 17); s_data = smp[(idx < 17) ? idx : 16];
      rdy2 = s_ready2;
      cycle();
      if (rdy2 && idx < 17) idx++;
      check_eq("t4_seq", fir_d2, (k < 17) ? smp[k] : 16'sh0000);
    end
    check_eq("t4_acc17", idx, 17);
    s_valid = 0;

    // Randomized traffic
    for (int c = 0; c < 1600; c++) begin
      s_valid = ($urandom_range(0, 99) < (((c / 200) % 2 == 1) ? 60 : 97));
      s_data = DW'($urandom);
      flush = ($urandom_range(0, 59) == 0);
      underrun_clr = ($urandom_range(0, 7) == 0);
      cycle();
    end
    s_valid = 0; flush = 0; underrun_clr = 0;
    repeat (4) cycle();

    // Asynchronous reset mid-stream
    s_valid = 1;
    for (int i = 0; i < 10; i++) begin s_data = DW'($urandom_range(1, 32767)); cycle(); end
    do_reset();
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
